// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response bundle between two issuers, arbiter and consumer
interface alu_share_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [CTRL_W-1:0] req0_ctrl;

    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [CTRL_W-1:0] req1_ctrl;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
// One op in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it until consumed.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [CTRL_W-1:0]   alu_control,
    input  logic [WIDTH-1:0]    alu_out,
    input  logic                alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [CTRL_W-1:0] alu_control_q, alu_control_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic grant;
    logic accept;
    logic err_op;

    // With both requesters valid the one not served last wins; otherwise the sole valid one.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
        accept = rst_n && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
        err_op = (alu_control_q == CTRL_W'(6)) || (alu_control_q == CTRL_W'(7));
    end

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (grant) begin
                        alu_a_d       = bus.req1_a;
                        alu_b_d       = bus.req1_b;
                        alu_control_d = bus.req1_ctrl;
                    end else begin
                        alu_a_d       = bus.req0_a;
                        alu_b_d       = bus.req0_b;
                        alu_control_d = bus.req0_ctrl;
                    end
                    id_d    = grant;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                // Undefined opcodes leave the ALU output unknown, so it is replaced, not forwarded.
                if (err_op) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_out;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so that requester 0 wins the first contended arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_control    = alu_control_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam int WIDTH  = 32;
    localparam int CTRL_W = 3;

    typedef struct packed {
        logic        id;
        logic        err;
        logic        zero;
        logic [31:0] result;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) bus ();

    logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
    logic [CTRL_W-1:0] alu_control;
    logic              alu_zero;

    alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    // Stand-in for the shared ALU; undefined opcodes produce X on purpose.
    always_comb begin
        case (alu_control)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_b;
            3'd5: alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_out = {WIDTH{1'bx}};
        endcase
        alu_zero = (alu_out == '0);
    end

    int total = 0;
    int bad = 0;

    function automatic rsp_t ref_rsp(input logic id, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.id = id;
        r.err = 1'b0;
        case (c)
            3'd0: r.result = a + b;
            3'd1: r.result = a - b;
            3'd2: r.result = a & b;
            3'd3: r.result = a | b;
            3'd4: r.result = b;
            3'd5: r.result = (a < b) ? 32'd1 : 32'd0;
            default: begin r.result = 32'd0; r.err = 1'b1; end
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    function automatic rsp_t got_rsp();
        return {bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_result};
    endfunction

    task automatic drive(input logic p, input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        if (!p) begin
            bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 3'd0, 32'd1, 32'd2);
        drive(1'b1, 1'b1, 3'd1, 32'd3, 32'd4);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b want 00", {bus.req1_ready, bus.req0_ready});
        end
        total++;
        if ({bus.rsp_valid, got_rsp()} !== 36'd0) begin
            bad++; $display("FAIL reset_rsp: got %h want 0", {bus.rsp_valid, got_rsp()});
        end
        total++;
        if ({alu_a, alu_b, alu_control} !== 67'd0) begin
            bad++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_control});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_add_latency();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, 32'd5, 32'd7);
        @(negedge clk);
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            bad++; $display("FAIL add_accept: got %b want 01", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, alu_a, alu_b, alu_control} !== {1'b0, 32'd5, 32'd7, 3'd0}) begin
            bad++; $display("FAIL add_exec: got %h want %h", {bus.rsp_valid, alu_a, alu_b, alu_control}, {1'b0, 32'd5, 32'd7, 3'd0});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, got_rsp()} !== {1'b1, ref_rsp(1'b0, 3'd0, 32'd5, 32'd7)}) begin
            bad++; $display("FAIL add_rsp: got %h want %h", {bus.rsp_valid, got_rsp()}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd12});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.rsp_result, alu_a} !== {1'b0, 32'd12, 32'd5}) begin
            bad++; $display("FAIL add_hold: got %h want %h", {bus.rsp_valid, bus.rsp_result, alu_a}, {1'b0, 32'd12, 32'd5});
        end
    endtask

    task automatic test_ops();
        logic        t_p [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  t_c [8] = '{3'd1, 3'd5, 3'd4, 3'd2, 3'd3, 3'd5, 3'd7, 3'd6};
        logic [31:0] t_a [8] = '{32'd9, 32'd3, 32'h1234, 32'hF0F0_1234, 32'h0000_FF00, 32'd5, 32'hAAAA_5555, 32'd1};
        logic [31:0] t_b [8] = '{32'd9, 32'd5, 32'hDEAD, 32'h0FF0_FFFF, 32'h00FF_0000, 32'd3, 32'h1234_5678, 32'd1};
        for (int i = 0; i < 8; i++) begin
            rsp_t exp_r;
            bit got;
            exp_r = ref_rsp(t_p[i], t_c[i], t_a[i], t_b[i]);
            @(posedge clk); #1;
            drive(t_p[i], 1'b1, t_c[i], t_a[i], t_b[i]);
            got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                @(negedge clk);
                if (t_p[i] ? bus.req1_ready : bus.req0_ready) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            total++;
            if (!got) begin bad++; $display("FAIL op%0d_accept: got no ready want ready", i); end
            @(posedge clk); #1;
            drive(t_p[i], 1'b0, 3'd0, 32'd0, 32'd0);
            got = 1'b0;
            for (int w = 0; w < 4 && !got; w++) begin
                @(negedge clk);
                if (bus.rsp_valid === 1'b1) got = 1'b1;
                else begin @(posedge clk); #1; end
            end
            total++;
            if (!got || got_rsp() !== exp_r || $isunknown(got_rsp())) begin
                bad++; $display("FAIL op%0d_rsp: got valid=%b %h want %h", i, got, got_rsp(), exp_r);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [2:0]  c [2];
        logic [31:0] a [2], b [2];
        rsp_t q[$];
        int k = 0;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            c[p] = 3'($urandom_range(0, 5)); a[p] = $urandom; b[p] = $urandom;
            drive(1'(p), 1'b1, c[p], a[p], b[p]);
        end
        for (int i = 0; i < 24 && k < 4; i++) begin
            logic g;
            bit hit = 1'b0;
            @(negedge clk);
            total++;
            if (bus.req0_ready && bus.req1_ready) begin
                bad++; $display("FAIL rr_two_readies: got 11 want at most one");
            end
            if (bus.rsp_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin bad++; $display("FAIL rr_rsp: got spurious %h want none", got_rsp()); end
                else begin
                    rsp_t e = q.pop_front();
                    if (got_rsp() !== e) begin bad++; $display("FAIL rr_rsp: got %h want %h", got_rsp(), e); end
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                g = bus.req1_ready;
                total++;
                if (g !== 1'(k % 2)) begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", k, g, k % 2); end
                q.push_back(ref_rsp(g, c[g], a[g], b[g]));
                k++;
                hit = 1'b1;
            end
            @(posedge clk); #1;
            if (hit) begin
                c[g] = 3'($urandom_range(0, 5)); a[g] = $urandom; b[g] = $urandom;
                drive(g, 1'b1, c[g], a[g], b[g]);
            end
        end
        total++;
        if (k != 4) begin bad++; $display("FAIL rr_count: got %0d grants want 4", k); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        rsp_t e0, e1;
        bit got;
        do_reset();
        e0 = ref_rsp(1'b0, 3'd0, 32'd1, 32'd2);
        e1 = ref_rsp(1'b1, 3'd3, 32'h00F0, 32'h0F00);
        drive(1'b0, 1'b1, 3'd0, 32'd1, 32'd2);
        drive(1'b1, 1'b1, 3'd3, 32'h00F0, 32'h0F00);
        @(negedge clk);
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            bad++; $display("FAIL bp_first_grant: got %b want 01", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({bus.rsp_valid, got_rsp(), bus.req1_ready, bus.req0_ready} !== {1'b1, e0, 2'b00}) begin
                bad++; $display("FAIL bp_hold%0d: got %h want %h", i, {bus.rsp_valid, got_rsp(), bus.req1_ready, bus.req0_ready}, {1'b1, e0, 2'b00});
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            bad++; $display("FAIL bp_pending_accept: got %b want 10", {bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        got = 1'b0;
        for (int w = 0; w < 4 && !got; w++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!got || got_rsp() !== e1) begin
            bad++; $display("FAIL bp_second_rsp: got valid=%b %h want %h", got, got_rsp(), e1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, 32'd11, 32'd22);
        @(negedge clk);
        total++;
        if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL rm_accept: got %b want 1", bus.req0_ready); end
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 3'd1, 32'd8, 32'd2);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.rsp_valid, got_rsp(), alu_a, alu_b, alu_control, bus.req1_ready, bus.req0_ready} !== 105'd0) begin
            bad++; $display("FAIL rm_async: got %h want 0", {bus.rsp_valid, got_rsp(), alu_a, alu_b, alu_control, bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b001) begin
            bad++; $display("FAIL rm_after: got %b want 001", {bus.rsp_valid, bus.req1_ready, bus.req0_ready});
        end
        @(posedge clk); #1;
        idle_inputs();
        for (int w = 0; w < 4; w++) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic        v [2] = '{1'b0, 1'b0};
        logic [2:0]  c [2];
        logic [31:0] a [2], b [2];
        bit          acc [2] = '{1'b0, 1'b0};
        bit busy = 1'b0, hs = 1'b0, lg = 1'b1;
        int acc_cyc = 0;
        rsp_t q[$];
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit e0, e1, ev, g;
            @(posedge clk); #1;
            if (hs) begin busy = 1'b0; hs = 1'b0; end
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin v[p] = 1'b0; acc[p] = 1'b0; end
                if (!v[p] && $urandom_range(0, 2) != 0) begin
                    v[p] = 1'b1; c[p] = 3'($urandom_range(0, 7)); a[p] = $urandom;
                    b[p] = ($urandom_range(0, 3) == 0) ? a[p] : $urandom;
                end
                drive(1'(p), v[p], c[p], a[p], b[p]);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e0 = 1'b0; e1 = 1'b0; g = 1'b0;
            if (!busy && (v[0] || v[1])) begin
                g = (v[0] && v[1]) ? !lg : v[1];
                if (g) e1 = 1'b1; else e0 = 1'b1;
            end
            total++;
            if ({bus.req1_ready, bus.req0_ready} !== {e1, e0}) begin
                bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, {bus.req1_ready, bus.req0_ready}, {e1, e0});
            end
            ev = busy && (cyc >= acc_cyc + 2);
            total++;
            if (bus.rsp_valid !== ev) begin
                bad++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, bus.rsp_valid, ev);
            end
            if (ev && bus.rsp_ready) begin
                rsp_t e = q.pop_front();
                total++;
                if (got_rsp() !== e) begin
                    bad++; $display("FAIL rnd_rsp c%0d: got %h want %h", cyc, got_rsp(), e);
                end
                lg = e.id;
                hs = 1'b1;
            end
            if (e0 || e1) begin
                acc[g] = 1'b1; busy = 1'b1; acc_cyc = cyc;
                q.push_back(ref_rsp(g, c[g], a[g], b[g]));
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_add_latency();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
